// File: rtl/branch_squash_unit_pkg.sv
// Shared types for the branch-squash path: rob index layout, writeback/squash payloads, FSM states.
// The rob_older() helper is the single age rule used by the ROB, IQ and this unit.
package branch_squash_unit_pkg;

    localparam int XLEN       = 32;
    localparam int ROB_SLOT_W = 5;

    typedef struct packed {
        logic                  flag;
        logic [ROB_SLOT_W-1:0] slot;
    } robIdx_t;

    localparam int ROB_PTR_W = $bits(robIdx_t);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        SQUASH
    } bsu_state_e;

    typedef struct packed {
        robIdx_t           rob_idx;
        logic              has_mispred;
        logic              branch_taken;
        logic [XLEN-1:0]   target_pc;
        logic [XLEN-1:0]   branch_npc;
    } branchwbInfo_t;

    typedef struct packed {
        logic              dueToBranch;
        logic              branch_taken;
        logic [XLEN-1:0]   arch_pc;
    } squashInfo_t;

    // Same wrap flag means plain slot order; differing flags means the lower slot has wrapped.
    function automatic logic rob_older(input robIdx_t a, input robIdx_t b);
        if (a.flag == b.flag) begin
            return a.slot < b.slot;
        end
        return a.slot > b.slot;
    endfunction

endpackage

// File: rtl/bsu_oldest_select.sv
// Combinational picker: oldest valid mispredicting writeback among NUM_BRU ports,
// along with its redirect target (target if taken, fall-through otherwise).
module bsu_oldest_select
    import branch_squash_unit_pkg::*;
#(
    parameter int NUM_BRU = 2
) (
    input  logic                        wb_vld [NUM_BRU],
    input  branchwbInfo_t               wb_info [NUM_BRU],
    output logic                        cand_vld,
    output robIdx_t                     cand_rob_idx,
    output logic                        cand_taken,
    output logic [XLEN-1:0]             cand_pc
);

    logic              sel_vld;
    robIdx_t           sel_rob_idx;
    logic              sel_taken;
    logic [XLEN-1:0]   sel_pc;

    // Running fold: each port challenges the current best with the shared age rule.
    always_comb begin
        sel_vld     = 1'b0;
        sel_rob_idx = '0;
        sel_taken   = 1'b0;
        sel_pc      = '0;
        for (int i = 0; i < NUM_BRU; i++) begin
            if (wb_vld[i] && wb_info[i].has_mispred &&
                (!sel_vld || rob_older(wb_info[i].rob_idx, sel_rob_idx))) begin
                sel_vld     = 1'b1;
                sel_rob_idx = wb_info[i].rob_idx;
                sel_taken   = wb_info[i].branch_taken;
                sel_pc      = wb_info[i].branch_taken ? wb_info[i].target_pc
                                                      : wb_info[i].branch_npc;
            end
        end
    end

    assign cand_vld     = sel_vld;
    assign cand_rob_idx = sel_rob_idx;
    assign cand_taken   = sel_taken;
    assign cand_pc      = sel_pc;

endmodule

// File: rtl/branch_squash_unit.sv
// Holds the oldest in-flight mispredicted branch and issues a one-cycle branch squash when it commits.
// Optional BSU_EARLY_REDIRECT_EN adds an early frontend redirect on capture/replace.
module branch_squash_unit
    import branch_squash_unit_pkg::*;
#(
    parameter int NUM_BRU      = 2,
    parameter int COMMIT_WIDTH = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_BRU-1:0]                      i_wb_vld,
    input  branchwbInfo_t [NUM_BRU-1:0]             i_wb_info,
    input  logic [COMMIT_WIDTH-1:0]                 i_commit_vld,
    input  logic [COMMIT_WIDTH-1:0][ROB_PTR_W-1:0]  i_commit_robIdx,
    input  logic                                    i_ext_squash,
`ifdef BSU_EARLY_REDIRECT_EN
    output logic                                    o_early_redirect_vld,
    output logic [XLEN-1:0]                         o_early_redirect_pc,
`endif
    output logic                                    o_pending,
    output logic [ROB_PTR_W-1:0]                    o_pending_robIdx,
    output logic                                    o_squash_vld,
    output squashInfo_t                             o_squash_info
);

    bsu_state_e        state;
    logic              held_taken;
    logic [XLEN-1:0]   held_pc;

    logic              sel_vld_arr [NUM_BRU];
    branchwbInfo_t     sel_info_arr [NUM_BRU];
    logic              cand_vld;
    robIdx_t           cand_rob_idx;
    logic              cand_taken;
    logic [XLEN-1:0]   cand_pc;
    logic              commit_hit;
    logic              cand_older;

    always_comb begin
        for (int i = 0; i < NUM_BRU; i++) begin
            sel_vld_arr[i]  = i_wb_vld[i];
            sel_info_arr[i] = i_wb_info[i];
        end
    end

    bsu_oldest_select #(
        .NUM_BRU      (NUM_BRU)
    ) u_oldest_select (
        .wb_vld       (sel_vld_arr),
        .wb_info      (sel_info_arr),
        .cand_vld     (cand_vld),
        .cand_rob_idx (cand_rob_idx),
        .cand_taken   (cand_taken),
        .cand_pc      (cand_pc)
    );

    always_comb begin
        commit_hit = 1'b0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (i_commit_vld[k] && (i_commit_robIdx[k] == o_pending_robIdx)) begin
                commit_hit = 1'b1;
            end
        end
    end

    assign cand_older = rob_older(cand_rob_idx, robIdx_t'(o_pending_robIdx));

    // The pending rob index register doubles as the held entry's identity; external squash overrides all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            held_taken       <= 1'b0;
            held_pc          <= '0;
            o_pending        <= 1'b0;
            o_pending_robIdx <= '0;
            o_squash_vld     <= 1'b0;
            o_squash_info    <= '0;
`ifdef BSU_EARLY_REDIRECT_EN
            o_early_redirect_vld <= 1'b0;
            o_early_redirect_pc  <= '0;
`endif
        end else begin
            o_squash_vld  <= 1'b0;
            o_squash_info <= '0;
`ifdef BSU_EARLY_REDIRECT_EN
            o_early_redirect_vld <= 1'b0;
`endif
            if (i_ext_squash) begin
                state     <= IDLE;
                o_pending <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cand_vld) begin
                            state            <= PEND;
                            o_pending        <= 1'b1;
                            o_pending_robIdx <= cand_rob_idx;
                            held_taken       <= cand_taken;
                            held_pc          <= cand_pc;
`ifdef BSU_EARLY_REDIRECT_EN
                            o_early_redirect_vld <= 1'b1;
                            o_early_redirect_pc  <= cand_pc;
`endif
                        end
                    end
                    PEND: begin
                        if (commit_hit) begin
                            state                      <= SQUASH;
                            o_pending                  <= 1'b0;
                            o_squash_vld               <= 1'b1;
                            o_squash_info.dueToBranch  <= 1'b1;
                            o_squash_info.branch_taken <= held_taken;
                            o_squash_info.arch_pc      <= held_pc;
                        end else if (cand_vld && cand_older) begin
                            o_pending_robIdx <= cand_rob_idx;
                            held_taken       <= cand_taken;
                            held_pc          <= cand_pc;
`ifdef BSU_EARLY_REDIRECT_EN
                            o_early_redirect_vld <= 1'b1;
                            o_early_redirect_pc  <= cand_pc;
`endif
                        end
                    end
                    SQUASH: begin
                        state <= IDLE;
                    end
                    default: begin
                        state     <= IDLE;
                        o_pending <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
